// File: rtl/cafeteira_param.sv
// Coffee machine FSM: idle -> coffee -> (optional milk) -> ready, with cancel and type rejection.
// Optional cup counter output 'xicaras' is enabled by defining CAFETEIRA_STATS_EN.
module cafeteira_param #(
   parameter int T_CURTO = 2,
   parameter int T_LONGO = 4,
   parameter int T_LEITE = 2,
   parameter int CW      = 4,
   parameter int NW      = 8
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [1:0]    tipo,
   input  logic          start,
   input  logic          cancel,
   input  logic          ack,
   output logic          c,
   output logic          l,
   output logic          f,
   output logic          busy,
   output logic          erro
`ifdef CAFETEIRA_STATS_EN
   ,
   output logic [NW-1:0] xicaras
`endif
);

   localparam logic [1:0] S_OCIOSO = 2'd0;
   localparam logic [1:0] S_CAFE   = 2'd1;
   localparam logic [1:0] S_LEITE  = 2'd2;
   localparam logic [1:0] S_PRONTO = 2'd3;

   localparam logic [1:0] TIPO_CURTO   = 2'b00;
   localparam logic [1:0] TIPO_LONGO   = 2'b01;
   localparam logic [1:0] TIPO_LEITE   = 2'b10;
   localparam logic [1:0] TIPO_INVALID = 2'b11;

   // Terminal counter values: a phase of N cycles ends when the counter reads N-1.
   localparam logic [CW-1:0] LAST_CURTO = CW'(T_CURTO - 1);
   localparam logic [CW-1:0] LAST_LONGO = CW'(T_LONGO - 1);
   localparam logic [CW-1:0] LAST_LEITE = CW'(T_LEITE - 1);

   logic [1:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_tipo;
   logic          r_erro;

   logic [1:0]    w_next_state;
   logic [CW-1:0] w_next_cnt;
   logic [1:0]    w_next_tipo;
   logic          w_reject;
   logic [CW-1:0] w_cafe_last;

   assign w_cafe_last = (r_tipo == TIPO_LONGO) ? LAST_LONGO : LAST_CURTO;

   // Cancel is checked before the phase-end test so it wins on a phase's final cycle.
   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      w_next_tipo  = r_tipo;
      w_reject     = 1'b0;
      case (r_state)
         S_OCIOSO: begin
            if (start) begin
               if (tipo == TIPO_INVALID) begin
                  w_reject = 1'b1;
               end else begin
                  w_next_state = S_CAFE;
                  w_next_tipo  = tipo;
                  w_next_cnt   = '0;
               end
            end
         end
         S_CAFE: begin
            if (cancel) begin
               w_next_state = S_OCIOSO;
               w_next_cnt   = '0;
            end else if (r_cnt == w_cafe_last) begin
               w_next_state = (r_tipo == TIPO_LEITE) ? S_LEITE : S_PRONTO;
               w_next_cnt   = '0;
            end else begin
               w_next_cnt = r_cnt + 1'b1;
            end
         end
         S_LEITE: begin
            if (cancel) begin
               w_next_state = S_OCIOSO;
               w_next_cnt   = '0;
            end else if (r_cnt == LAST_LEITE) begin
               w_next_state = S_PRONTO;
               w_next_cnt   = '0;
            end else begin
               w_next_cnt = r_cnt + 1'b1;
            end
         end
         S_PRONTO: begin
            if (ack) begin
               w_next_state = S_OCIOSO;
               w_next_cnt   = '0;
            end
         end
         default: begin
            w_next_state = S_OCIOSO;
            w_next_cnt   = '0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= S_OCIOSO;
         r_cnt   <= '0;
         r_tipo  <= TIPO_CURTO;
         r_erro  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
         r_tipo  <= w_next_tipo;
         r_erro  <= w_reject;
      end
   end

   assign c    = (r_state == S_CAFE);
   assign l    = (r_state == S_LEITE);
   assign f    = (r_state == S_PRONTO);
   assign busy = (r_state != S_OCIOSO);
   assign erro = r_erro;

`ifdef CAFETEIRA_STATS_EN
   logic [NW-1:0] r_xicaras;
   logic          w_done;

   assign w_done = (r_state == S_PRONTO) && ack;

   // Completed-drink counter saturates instead of wrapping.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_xicaras <= '0;
      end else if (w_done && (r_xicaras != {NW{1'b1}})) begin
         r_xicaras <= r_xicaras + 1'b1;
      end
   end

   assign xicaras = r_xicaras;
`endif

endmodule

// File: tb/tb_cafeteira_param.sv
// Self-checking bench for cafeteira_param: vector table plus hand-written reset/saturation sequences.
module tb_cafeteira_param;

   logic       clock;
   logic       reset;
   logic [1:0] tipo;
   logic       start;
   logic       cancel;
   logic       ack;
   logic       c;
   logic       l;
   logic       f;
   logic       busy;
   logic       erro;
`ifdef CAFETEIRA_STATS_EN
   logic [1:0] xicaras;
`endif

   int checks;
   int errors;

   typedef struct {
      logic       rst;
      logic [1:0] tipo;
      logic       start;
      logic       cancel;
      logic       ack;
      logic [4:0] expOut;
      int         expX;
      string      name;
   } vec_t;

   vec_t vecs[$];

   cafeteira_param #(
      .T_CURTO(2),
      .T_LONGO(4),
      .T_LEITE(2),
      .CW(4),
      .NW(2)
   ) dut (
      .clock(clock),
      .reset(reset),
      .tipo(tipo),
      .start(start),
      .cancel(cancel),
      .ack(ack),
      .c(c),
      .l(l),
      .f(f),
      .busy(busy),
      .erro(erro)
`ifdef CAFETEIRA_STATS_EN
      ,
      .xicaras(xicaras)
`endif
   );

   // Free-running clock, 10 ns period.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic vec_t mk(input logic r, input logic [1:0] t, input logic s,
                               input logic cn, input logic a, input logic [4:0] e,
                               input int x, input string n);
      vec_t v;
      v.rst = r; v.tipo = t; v.start = s; v.cancel = cn; v.ack = a;
      v.expOut = e; v.expX = x; v.name = n;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Drive one vector at the falling edge, sample just after the following rising edge.
   task automatic applyStimulus(input vec_t v);
      @(negedge clock);
      reset = v.rst; tipo = v.tipo; start = v.start; cancel = v.cancel; ack = v.ack;
      @(posedge clock);
      #1;
      checkOutput({v.name, " {c,l,f,busy,erro}"}, {27'd0, c, l, f, busy, erro}, {27'd0, v.expOut});
`ifdef CAFETEIRA_STATS_EN
      checkOutput({v.name, " xicaras"}, {30'd0, xicaras}, v.expX);
`endif
   endtask

   task automatic runShortDrink(input int expCount);
      @(negedge clock);
      tipo = 2'b00; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      @(negedge clock);
      checkOutput("short drink ready", {31'd0, f}, 32'd1);
      ack = 1'b1;
      @(negedge clock);
      ack = 1'b0;
      checkOutput("short drink back to idle", {31'd0, busy}, 32'd0);
`ifdef CAFETEIRA_STATS_EN
      checkOutput("xicaras count", {30'd0, xicaras}, expCount);
`else
      if (expCount < 0) $display("[TB] unused count %0d", expCount);
`endif
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b0; tipo = 2'b00; start = 1'b0; cancel = 1'b0; ack = 1'b0;

      vecs.push_back(mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 5'b00000, 0, "reset state"));
      vecs.push_back(mk(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 5'b00000, 0, "idle after reset"));
      vecs.push_back(mk(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 5'b10010, 0, "short cafe 1"));
      vecs.push_back(mk(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 5'b10010, 0, "short cafe 2"));
      vecs.push_back(mk(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 5'b00110, 0, "short pronto"));
      vecs.push_back(mk(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 5'b00110, 0, "pronto held"));
      vecs.push_back(mk(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 5'b00110, 0, "start ignored in pronto"));
      vecs.push_back(mk(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 5'b00110, 0, "cancel ignored in pronto"));
      vecs.push_back(mk(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 5'b00000, 1, "ack to idle"));
      vecs.push_back(mk(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 5'b10010, 1, "milk cafe 1"));
      vecs.push_back(mk(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 5'b10010, 1, "milk cafe 2 tipo toggled"));
      vecs.push_back(mk(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 5'b01010, 1, "milk leite 1"));
      vecs.push_back(mk(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 5'b01010, 1, "milk leite 2"));
      vecs.push_back(mk(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 5'b00110, 1, "milk pronto"));
      vecs.push_back(mk(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 5'b00000, 2, "milk ack"));
      vecs.push_back(mk(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 5'b10010, 2, "long cafe 1"));
      vecs.push_back(mk(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 5'b10010, 2, "long cafe 2 ack ignored"));
      vecs.push_back(mk(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 5'b10010, 2, "long cafe 3"));
      vecs.push_back(mk(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 5'b10010, 2, "long cafe 4"));
      vecs.push_back(mk(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 5'b00000, 2, "cancel on last cafe cycle"));
      vecs.push_back(mk(1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 5'b00001, 2, "invalid tipo erro"));
      vecs.push_back(mk(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 5'b00000, 2, "erro one cycle"));
      vecs.push_back(mk(1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 5'b10010, 2, "start wins over cancel"));
      vecs.push_back(mk(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 5'b00000, 2, "cancel in cafe"));
      vecs.push_back(mk(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 5'b10010, 2, "milk2 cafe 1"));
      vecs.push_back(mk(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 5'b10010, 2, "milk2 cafe 2"));
      vecs.push_back(mk(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 5'b01010, 2, "milk2 leite 1"));
      vecs.push_back(mk(1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 5'b00000, 2, "cancel in leite"));

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
      end

      // Asynchronous reset in the middle of the milk phase.
      @(negedge clock);
      tipo = 2'b10; start = 1'b1; cancel = 1'b0; ack = 1'b0;
      @(negedge clock);
      start = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #2;
      checkOutput("in leite before reset", {31'd0, l}, 32'd1);
      reset = 1'b0;
      #1;
      checkOutput("async reset outputs", {28'd0, c, l, f, busy}, 32'd0);
`ifdef CAFETEIRA_STATS_EN
      checkOutput("async reset xicaras", {30'd0, xicaras}, 32'd0);
`endif

      // Start presented together with reset release is taken on the first edge.
      @(negedge clock);
      reset = 1'b1; tipo = 2'b00; start = 1'b1;
      #1;
      checkOutput("no accept before edge", {30'd0, c, busy}, 32'd0);
      @(posedge clock);
      #1;
      checkOutput("accept on first edge", {30'd0, c, busy}, 32'd3);
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      @(negedge clock);
      checkOutput("post-reset drink ready", {31'd0, f}, 32'd1);
      ack = 1'b1;
      @(negedge clock);
      ack = 1'b0;
`ifdef CAFETEIRA_STATS_EN
      checkOutput("post-reset xicaras", {30'd0, xicaras}, 32'd1);
`endif

      // Four more drinks drive the 2-bit counter into saturation at 3.
      runShortDrink(2);
      runShortDrink(3);
      runShortDrink(3);
      runShortDrink(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
